// File: rtl/final_frame_reader_pkg.sv
// Shared encodings and frame-geometry constants for the final frame read-out path.
package final_frame_reader_pkg;

  typedef enum logic [1:0] {
    PLANE_Y  = 2'd0,
    PLANE_CB = 2'd1,
    PLANE_CR = 2'd2
  } plane_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_Y  = 3'd1,
    RD_CB = 3'd2,
    RD_CR = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // 32-bit words per macroblock in each plane (4 pixels per word).
  localparam int WORDS_PER_MB_Y  = 64;
  localparam int WORDS_PER_MB_CB = 16;
  localparam int WORDS_PER_MB_CR = 16;
  localparam int MAX_MBS         = 21845;

  typedef struct packed {
    plane_e plane;
    logic   sof;
    logic   eol;
  } side_t;

  localparam int SIDE_W = $bits(side_t);

endpackage

// File: rtl/final_frame_reader_fifo2.sv
// Two-entry FIFO carrying a word plus its framing sideband; push into a full FIFO
// is accepted only together with a pop, which keeps occupancy unchanged without a bubble.
module frame_reader_fifo2 #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == 2'd0);
  assign full_o     = (count_q == 2'd2);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/final_frame_reader.sv
// Reads a completed frame out of the final frame RAM as Y, Cb, Cr in raster order.
// First read one cycle after start, first word valid two cycles later; reads are credited against the 2-entry buffer.
module final_frame_reader
  import final_frame_reader_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              end_of_lastMB_DF,
  input  logic [7:0]        pic_width_in_mbs_minus1,
  input  logic [7:0]        pic_height_in_map_units_minus1,
  output logic              final_frame_RAM_rd,
  output logic [ADDR_W-1:0] final_frame_RAM_rd_addr,
  input  logic [DATA_W-1:0] final_frame_RAM_dout,
  output logic              frame_out_valid,
  input  logic              frame_out_ready,
  output logic [DATA_W-1:0] frame_out_data,
  output logic [1:0]        frame_out_plane,
  output logic              frame_out_sof,
  output logic              frame_out_eol,
  output logic              frame_reader_busy,
  output logic              frame_read_done
);

  localparam int ENT_W = SIDE_W + DATA_W;

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d, x_max;
  logic [11:0]       y_q, y_d, y_max;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wm1_q, hm1_q;
  logic              inflight_q;
  side_t             side_q, side_cur, head_side;
  logic              reading, luma, x_last, y_last;
  logic              rd, room, pop, done;
  logic [1:0]        occ_next, fifo_count;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_head;

  assign reading = (state_q == RD_Y) || (state_q == RD_CB) || (state_q == RD_CR);
  assign luma    = (state_q == RD_Y);
  assign x_max   = luma ? {wm1_q, 2'b11} : {1'b0, wm1_q, 1'b1};
  assign y_max   = luma ? {hm1_q, 4'hF}  : {1'b0, hm1_q, 3'h7};
  assign x_last  = (x_q == x_max);
  assign y_last  = (y_q == y_max);

  // Occupancy the buffer will hold after this edge if no new read is issued;
  // counting this cycle's pop is what sustains one word per clock.
  assign pop      = !fifo_empty && frame_out_ready;
  assign occ_next = fifo_count + {1'b0, inflight_q} - {1'b0, pop};
  assign room     = !fifo_full || pop;
  assign rd       = reading && room && (occ_next < 2'd2);

  always_comb begin
    side_cur       = '0;
    side_cur.plane = PLANE_Y;
    if (state_q == RD_CB) side_cur.plane = PLANE_CB;
    if (state_q == RD_CR) side_cur.plane = PLANE_CR;
    side_cur.sof   = (x_q == 10'd0) && (y_q == 12'd0);
    side_cur.eol   = x_last;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (end_of_lastMB_DF) begin
          state_d = RD_Y;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      RD_Y, RD_CB, RD_CR: begin
        if (rd) begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d = '0;
              case (state_q)
                RD_Y:    state_d = RD_CB;
                RD_CB:   state_d = RD_CR;
                default: state_d = DRAIN;
              endcase
            end else begin
              y_d = y_q + 12'd1;
            end
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      wm1_q      <= '0;
      hm1_q      <= '0;
      inflight_q <= 1'b0;
      side_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      inflight_q <= rd;
      if (rd) begin
        side_q <= side_cur;
      end
      if ((state_q == IDLE) && end_of_lastMB_DF) begin
        wm1_q <= pic_width_in_mbs_minus1;
        hm1_q <= pic_height_in_map_units_minus1;
      end
    end
  end

  frame_reader_fifo2 #(
    .WIDTH(ENT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (inflight_q),
    .push_dat_i({side_q, final_frame_RAM_dout}),
    .pop_i     (pop),
    .head_dat_o(fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign head_side               = side_t'(fifo_head[ENT_W-1:DATA_W]);
  assign final_frame_RAM_rd      = rd;
  assign final_frame_RAM_rd_addr = addr_q;
  assign frame_out_valid         = !fifo_empty;
  assign frame_out_data          = fifo_head[DATA_W-1:0];
  assign frame_out_plane         = head_side.plane;
  assign frame_out_sof           = head_side.sof;
  assign frame_out_eol           = head_side.eol;
  assign frame_reader_busy       = (state_q != IDLE);
  assign frame_read_done         = done;

endmodule

// File: tb/tb_final_frame_reader.sv
// Directed + randomized bench for final_frame_reader against a frame-level stream model.
module tb_final_frame_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pic_w;
  logic [7:0]  pic_h;
  logic        rd;
  logic [20:0] rd_addr;
  logic [31:0] dout;
  logic        valid;
  logic        ready;
  logic [31:0] odata;
  logic [1:0]  oplane;
  logic        osof;
  logic        oeol;
  logic        busy;
  logic        done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] salt  = 32'h0;

  always #5 clk = ~clk;

  final_frame_reader #(.ADDR_W(21), .DATA_W(32)) dut (
    .clk                           (clk),
    .reset                         (reset),
    .end_of_lastMB_DF              (start),
    .pic_width_in_mbs_minus1       (pic_w),
    .pic_height_in_map_units_minus1(pic_h),
    .final_frame_RAM_rd            (rd),
    .final_frame_RAM_rd_addr       (rd_addr),
    .final_frame_RAM_dout          (dout),
    .frame_out_valid               (valid),
    .frame_out_ready               (ready),
    .frame_out_data                (odata),
    .frame_out_plane               (oplane),
    .frame_out_sof                 (osof),
    .frame_out_eol                 (oeol),
    .frame_reader_busy             (busy),
    .frame_read_done               (done)
  );

  // RAM model: word k holds k ^ salt, one-cycle read latency.
  always @(posedge clk) begin
    if (rd) dout <= {11'b0, rd_addr} ^ salt;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // mode: 0 ready high, 1 ready 1,0,0,1, 2 ready low for 20 cycles, 3 random.
  task automatic run_frame(input logic [7:0] wm1, input logic [7:0] hm1, input int mode,
                           input int extra_at, input int reset_after);
    logic [35:0] exp_q[$];
    logic [35:0] obs;
    logic [35:0] out_prev = '0;
    logic        stall_prev = 1'b0;
    logic        pop;
    int w = int'(wm1) + 1;
    int h = int'(hm1) + 1;
    int total = 96 * w * h;
    int a = 0;
    int c = 0;
    int issued = 0;
    int acc = 0;
    int done_c = -1;
    int last_acc = -1;
    int limit = 8 * total + 100;
    bit fin = 0;

    for (int p = 0; p < 3; p++) begin
      int wpr  = (p == 0) ? 4 * w : 2 * w;
      int rows = (p == 0) ? 16 * h : 8 * h;
      for (int r = 0; r < rows; r++) begin
        for (int k = 0; k < wpr; k++) begin
          logic [1:0] pl = 2'(p);
          logic sof_b = (r == 0) && (k == 0);
          logic eol_b = (k == wpr - 1);
          exp_q.push_back({pl, sof_b, eol_b, 32'(a) ^ salt});
          a++;
        end
      end
    end

    while (!fin && c < limit) begin
      start = (c == 0) || (c == extra_at);
      pic_w = (c == 0) ? wm1 : (wm1 ^ 8'h01);
      pic_h = (c == 0) ? hm1 : (hm1 ^ 8'h01);
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (c % 4 == 0) || (c % 4 == 3);
        2:       ready = (c > 20);
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
      if (reset_after > 0 && acc == reset_after) begin
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rd", rd, 0);
        return;
      end
      #1;
      obs = {oplane, osof, oeol, odata};
      chk("busy", busy, (c >= 1) && (done_c < 0));
      if (stall_prev) begin
        chk("stall_valid", valid, 1);
        chk("stall_data", obs, out_prev);
      end
      if (c == 1) chk("first_rd", rd, 1);
      if (c == 2) chk("valid_lat2", valid, 0);
      if (c == 3) chk("valid_lat3", valid, 1);
      pop = valid && ready;
      if (rd) begin
        chk("rd_addr", rd_addr, issued);
        chk("credit", (issued - acc - int'(pop)) < 2, 1);
        issued++;
      end
      if (pop) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else chk("word", obs, exp_q.pop_front());
        acc++;
        last_acc = c;
      end
      if (done) begin
        chk("done_time", c, last_acc + 1);
        chk("done_words", acc, total);
        if (done_c >= 0) chk("done_twice", 1, 0);
        done_c = c;
      end
      if (mode == 2 && c == 20) chk("stall_reads", issued, 2);
      if (done_c >= 0 && c == done_c + 1) fin = 1;
      stall_prev = valid && !ready;
      out_prev   = obs;
      @(negedge clk);
      c++;
    end

    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("rd_total", issued, total);
    chk("left_over", exp_q.size(), 0);
    if (mode == 0) chk("full_rate", last_acc, 3 + total - 1);
    if (mode == 2) chk("resume_rate", last_acc, 21 + total - 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    pic_w = 8'd0;
    pic_h = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {oplane, osof, oeol, odata}, 0);
    reset = 1'b0;
    @(negedge clk);

    salt = 32'h0;
    run_frame(8'd0, 8'd0, 0, -1, 0);
    salt = $urandom;
    run_frame(8'd1, 8'd0, 1, -1, 0);
    run_frame(8'd0, 8'd0, 0, 40, 0);
    run_frame(8'd1, 8'd1, 0, -1, 10);
    run_frame(8'd0, 8'd0, 0, -1, 0);
    run_frame(8'd0, 8'd0, 2, -1, 0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] rw = 8'($urandom_range(0, 2));
      logic [7:0] rh = 8'($urandom_range(0, 2));
      salt = $urandom;
      run_frame(rw, rh, 3, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
